// File: rtl/ob_pkg.sv
// Shared order-book types: opcodes, uids, the command record and table sizing.
package ob_pkg;

    typedef enum logic [3:0] {
        OpNop,
        OpBuyMarket,
        OpSellMarket,
        OpBuyLimit,
        OpSellLimit,
        OpBuyStopLoss,
        OpSellStopLoss,
        OpBuyStopLimit,
        OpSellStopLimit,
        OpCancel
    } opcode_e;

    typedef logic [7:0] uid_t;

    typedef struct packed {
        opcode_e     op;
        uid_t        uid;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;

    // Default number of entries in the conditional (stop) order table.
    localparam int unsigned CN_N = 4;

endpackage

// File: rtl/ob_cn_rr_arb.sv
// N-way round-robin arbiter. Search starts at the pointer; on an enabled grant the
// pointer moves to one past the winner, wrapping modulo N.
module ob_cn_rr_arb #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    logic [IDX_W-1:0] win_idx;

    // First requester at or after the pointer, in circular order.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned      idx;
            logic [IDX_W-1:0] cand;
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IDX_W'(idx);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant outputs and pointer advance, both gated by enable.
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = en_i & found;
        gnt_idx_o = win_idx;
        ptr_d     = ptr_q;
        if (gnt_vld_o) begin
            gnt_o[win_idx] = 1'b1;
            ptr_d = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ob_cn_table_ctrl.sv
// Far-side controller of the conditional order table: allocates new stop commands
// to free entries and drains matured (converted) commands to the book.
module ob_cn_table_ctrl
    import ob_pkg::*;
#(
    parameter  int unsigned N     = CN_N,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    input  cmd_t           in_cmd,
    output logic           in_rdy,
    output logic [N-1:0]   al_vld,
    output cmd_t           al_cmd_r,
    input  logic [N-1:0]   ent_busy_r,
    input  logic [N-1:0]   ent_mtr_r,
    input  cmd_t           ent_cmd_r [N],
    output logic [N-1:0]   dl_vld,
    output logic           out_vld,
    output cmd_t           out_cmd,
    input  logic           out_rdy,
    input  logic           cancel,
    input  uid_t           cancel_uid,
    output logic           cancel_hit,
    output logic [IDX_W:0] occ
);

    logic [N-1:0]     al_vld_q, al_vld_d;
    cmd_t             al_cmd_q, al_cmd_d;
    logic             out_vld_q, out_vld_d;
    cmd_t             out_cmd_q, out_cmd_d;

    logic [N-1:0]     free;
    logic [N-1:0]     lowest_free;
    logic             accept;
    logic             slot_free;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;

    // A pending allocation blocks its entry until the entry reports busy itself.
    always_comb begin
        free   = ~ent_busy_r & ~al_vld_q;
        in_rdy = |free;
        accept = in_vld & in_rdy;
    end

    // Lowest-index free entry as a one-hot vector.
    always_comb begin
        lowest_free = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (free[i]) begin
                lowest_free    = '0;
                lowest_free[i] = 1'b1;
            end
        end
    end

    // Allocation stage next state: strobe lasts one cycle per accept.
    always_comb begin
        al_vld_d = '0;
        al_cmd_d = al_cmd_q;
        if (accept) begin
            al_vld_d = lowest_free;
            al_cmd_d = in_cmd;
        end
    end

    assign slot_free = ~out_vld_q | out_rdy;

    ob_cn_rr_arb #(
        .N (N)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (slot_free),
        .req_i     (ent_mtr_r),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Cancel only looks at the output slot; entries handle their own cancels.
    always_comb begin
        cancel_hit = cancel & out_vld_q & (out_cmd_q.uid == cancel_uid);
    end

    // Output slot next state: a new grant wins over both drain and cancel.
    always_comb begin
        out_vld_d = out_vld_q;
        out_cmd_d = out_cmd_q;
        if (gnt_vld) begin
            out_vld_d = 1'b1;
            out_cmd_d = ent_cmd_r[gnt_idx];
        end else if (out_rdy || cancel_hit) begin
            out_vld_d = 1'b0;
        end
    end

    // Occupancy counts busy entries plus allocations still in flight.
    always_comb begin
        logic [N-1:0] used;
        used = ent_busy_r | al_vld_q;
        occ  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            occ = occ + (IDX_W + 1)'(used[i]);
        end
    end

    // Allocation and output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_vld_q  <= '0;
            al_cmd_q  <= '0;
            out_vld_q <= 1'b0;
            out_cmd_q <= '0;
        end else begin
            al_vld_q  <= al_vld_d;
            al_cmd_q  <= al_cmd_d;
            out_vld_q <= out_vld_d;
            out_cmd_q <= out_cmd_d;
        end
    end

    // Output drive.
    always_comb begin
        al_vld   = al_vld_q;
        al_cmd_r = al_cmd_q;
        dl_vld   = gnt;
        out_vld  = out_vld_q;
        out_cmd  = out_cmd_q;
    end

endmodule

// File: tb/tb_ob_cn_table_ctrl.sv
// Self-checking bench for ob_cn_table_ctrl: directed scenarios plus a randomized
// run against a cycle-level reference model of allocation, drain and cancel.
module tb_ob_cn_table_ctrl;
    import ob_pkg::*;

    localparam int unsigned N  = CN_N;
    localparam int unsigned OW = $clog2(N) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    cmd_t          in_cmd;
    logic          in_rdy;
    logic [N-1:0]  al_vld;
    cmd_t          al_cmd_r;
    logic [N-1:0]  ent_busy;
    logic [N-1:0]  ent_mtr;
    cmd_t          ent_cmd [N];
    logic [N-1:0]  dl_vld;
    logic          out_vld;
    cmd_t          out_cmd;
    logic          out_rdy;
    logic          cancel;
    uid_t          cancel_uid;
    logic          cancel_hit;
    logic [OW-1:0] occ;

    int errors = 0;
    int checks = 0;

    ob_cn_table_ctrl #(
        .N (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_cmd     (in_cmd),
        .in_rdy     (in_rdy),
        .al_vld     (al_vld),
        .al_cmd_r   (al_cmd_r),
        .ent_busy_r (ent_busy),
        .ent_mtr_r  (ent_mtr),
        .ent_cmd_r  (ent_cmd),
        .dl_vld     (dl_vld),
        .out_vld    (out_vld),
        .out_cmd    (out_cmd),
        .out_rdy    (out_rdy),
        .cancel     (cancel),
        .cancel_uid (cancel_uid),
        .cancel_hit (cancel_hit),
        .occ        (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cmd_t mk(input int u);
        cmd_t c;
        c       = '0;
        c.op    = OpBuyStopLoss;
        c.uid   = uid_t'(u);
        c.price = 16'(100 + u);
        c.qty   = 16'(3 * u + 1);
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.op    = opcode_e'(4'($urandom_range(1, 9)));
        c.uid   = uid_t'($urandom_range(0, 3));
        c.price = 16'($urandom);
        c.qty   = 16'($urandom);
        return c;
    endfunction

    task automatic idle_inputs();
        in_vld     = 1'b0;
        in_cmd     = '0;
        ent_busy   = '0;
        ent_mtr    = '0;
        out_rdy    = 1'b0;
        cancel     = 1'b0;
        cancel_uid = '0;
        for (int i = 0; i < int'(N); i++) ent_cmd[i] = mk(10 + i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks += 7;
        if (al_vld !== '0) begin
            errors++; $display("FAIL reset_al_vld got=%b want=0", al_vld);
        end
        if (dl_vld !== '0) begin
            errors++; $display("FAIL reset_dl_vld got=%b want=0", dl_vld);
        end
        if (out_vld !== 1'b0) begin
            errors++; $display("FAIL reset_out_vld got=%b want=0", out_vld);
        end
        if (out_cmd !== '0) begin
            errors++; $display("FAIL reset_out_cmd got=%h want=0", out_cmd);
        end
        if (al_cmd_r !== '0) begin
            errors++; $display("FAIL reset_al_cmd got=%h want=0", al_cmd_r);
        end
        if (occ !== '0) begin
            errors++; $display("FAIL reset_occ got=%0d want=0", occ);
        end
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Four back-to-back accepts; each entry turns busy two cycles after its accept.
    task automatic test_alloc_throughput();
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            in_vld   = 1'b1;
            in_cmd   = mk(k + 1);
            ent_busy = (k >= 1) ? N'((1 << (k - 1)) - 1) : '0;
            #1;
            if (k >= 1) begin
                checks += 2;
                if (al_vld !== N'(1 << (k - 1))) begin
                    errors++;
                    $display("FAIL alloc_onehot k=%0d got=%b want=%b", k, al_vld,
                             N'(1 << (k - 1)));
                end
                if (al_cmd_r.uid !== uid_t'(k)) begin
                    errors++;
                    $display("FAIL alloc_uid k=%0d got=%0d want=%0d", k, al_cmd_r.uid, k);
                end
            end
            checks++;
            if (in_rdy !== (k < 4)) begin
                errors++; $display("FAIL alloc_in_rdy k=%0d got=%b want=%b", k, in_rdy, k < 4);
            end
        end
        checks++;
        if (occ !== OW'(4)) begin
            errors++; $display("FAIL alloc_occ got=%0d want=4", occ);
        end
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic test_full_free();
        @(negedge clk);
        ent_busy = '1;
        in_vld   = 1'b1;
        in_cmd   = mk(9);
        #1;
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("FAIL full_in_rdy got=%b want=0", in_rdy);
        end
        @(negedge clk);
        ent_busy = 4'b1011;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL free_in_rdy got=%b want=1", in_rdy);
        end
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        checks++;
        if (al_vld !== 4'b0100) begin
            errors++; $display("FAIL free_al_vld got=%b want=0100", al_vld);
        end
        ent_busy = '0;
    endtask

    task automatic test_rr_drain();
        logic [N-1:0] mtr_seq [4];
        logic [N-1:0] dl_exp  [4];
        int           uid_exp [4];
        mtr_seq = '{4'b1011, 4'b1010, 4'b1000, 4'b0000};
        dl_exp  = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
        uid_exp = '{-1, 10, 11, 13};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            ent_mtr = mtr_seq[s];
            out_rdy = 1'b1;
            #1;
            checks++;
            if (dl_vld !== dl_exp[s]) begin
                errors++; $display("FAIL rr_dl s=%0d got=%b want=%b", s, dl_vld, dl_exp[s]);
            end
            if (s > 0) begin
                checks++;
                if (out_vld !== 1'b1 || out_cmd !== mk(uid_exp[s])) begin
                    errors++;
                    $display("FAIL rr_out s=%0d got=%b/%h want=1/%h", s, out_vld, out_cmd,
                             mk(uid_exp[s]));
                end
            end
        end
        // Pointer has wrapped to 0, so entry 0 wins over entry 3.
        @(negedge clk);
        ent_mtr = 4'b1001;
        #1;
        checks++;
        if (dl_vld !== 4'b0001) begin
            errors++; $display("FAIL rr_wrap got=%b want=0001", dl_vld);
        end
    endtask

    task automatic test_backpressure();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            ent_mtr = 4'b0100;
            out_rdy = 1'b0;
            #1;
            checks += 2;
            if (dl_vld !== '0) begin
                errors++; $display("FAIL bp_dl s=%0d got=%b want=0", s, dl_vld);
            end
            if (out_vld !== 1'b1 || out_cmd !== mk(10)) begin
                errors++;
                $display("FAIL bp_hold s=%0d got=%b/%h want=1/%h", s, out_vld, out_cmd, mk(10));
            end
        end
        @(negedge clk);
        out_rdy = 1'b1;
        #1;
        checks++;
        if (dl_vld !== 4'b0100) begin
            errors++; $display("FAIL bp_release got=%b want=0100", dl_vld);
        end
        @(negedge clk);
        ent_mtr = '0;
        out_rdy = 1'b0;
        #1;
        checks++;
        if (out_cmd !== mk(12)) begin
            errors++; $display("FAIL bp_out got=%h want=%h", out_cmd, mk(12));
        end
    endtask

    task automatic test_cancel();
        do_reset();
        @(negedge clk);
        ent_cmd[1] = mk(7);
        ent_mtr    = 4'b0010;
        out_rdy    = 1'b1;
        @(negedge clk);
        ent_mtr    = '0;
        out_rdy    = 1'b0;
        cancel     = 1'b1;
        cancel_uid = 8'd8;
        #1;
        checks += 2;
        if (cancel_hit !== 1'b0) begin
            errors++; $display("FAIL cancel_miss got=%b want=0", cancel_hit);
        end
        if (out_vld !== 1'b1 || out_cmd.uid !== 8'd7) begin
            errors++; $display("FAIL cancel_pre got=%b/%0d want=1/7", out_vld, out_cmd.uid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_vld !== 1'b1) begin
            errors++; $display("FAIL cancel_miss_keep got=%b want=1", out_vld);
        end
        cancel_uid = 8'd7;
        #1;
        checks++;
        if (cancel_hit !== 1'b1) begin
            errors++; $display("FAIL cancel_hit got=%b want=1", cancel_hit);
        end
        @(negedge clk);
        cancel = 1'b0;
        #1;
        checks++;
        if (out_vld !== 1'b0) begin
            errors++; $display("FAIL cancel_clear got=%b want=0", out_vld);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        ent_busy = 4'b0001;
        ent_mtr  = 4'b0100;
        out_rdy  = 1'b1;
        in_vld   = 1'b1;
        in_cmd   = mk(5);
        @(negedge clk);
        ent_mtr = '0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        #1;
        checks++;
        if (al_vld !== 4'b0010 || out_vld !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got=%b/%b want=0010/1", al_vld, out_vld);
        end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (al_vld !== '0 || dl_vld !== '0) begin
            errors++; $display("FAIL midrst_strobes got=%b/%b want=0/0", al_vld, dl_vld);
        end
        if (out_vld !== 1'b0 || out_cmd !== '0) begin
            errors++; $display("FAIL midrst_slot got=%b/%h want=0/0", out_vld, out_cmd);
        end
        if (al_cmd_r !== '0) begin
            errors++; $display("FAIL midrst_al_cmd got=%h want=0", al_cmd_r);
        end
        if (occ !== OW'(1)) begin
            errors++; $display("FAIL midrst_occ got=%0d want=1", occ);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        ent_mtr = '1;
        out_rdy = 1'b1;
        #1;
        checks++;
        if (dl_vld !== 4'b0001) begin
            errors++; $display("FAIL midrst_ptr got=%b want=0001", dl_vld);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Randomized run against a transaction-level model of the controller.
    task automatic test_random();
        int           m_ptr;
        logic         m_ov;
        cmd_t         m_oc;
        logic [N-1:0] m_pend;
        cmd_t         m_alc;
        do_reset();
        m_ptr = 0; m_ov = 1'b0; m_oc = '0; m_pend = '0; m_alc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0] fr;
            logic         e_rdy, e_hit;
            int           g;
            logic [N-1:0] e_dl;
            @(negedge clk);
            ent_busy = N'($urandom);
            ent_mtr  = N'($urandom) & N'($urandom);
            for (int i = 0; i < int'(N); i++) ent_cmd[i] = rnd_cmd();
            in_vld     = 1'($urandom);
            in_cmd     = rnd_cmd();
            out_rdy    = ($urandom_range(0, 3) != 0);
            cancel     = ($urandom_range(0, 2) == 0);
            cancel_uid = uid_t'($urandom_range(0, 3));
            #1;
            fr    = ~ent_busy & ~m_pend;
            e_rdy = (fr != '0);
            e_hit = cancel && m_ov && (m_oc.uid == cancel_uid);
            g     = -1;
            if (!m_ov || out_rdy) begin
                for (int k = 0; k < int'(N); k++) begin
                    int j;
                    j = (m_ptr + k) % int'(N);
                    if (g < 0 && ent_mtr[j]) g = j;
                end
            end
            e_dl = (g >= 0) ? N'(1 << g) : '0;
            checks += 8;
            if (in_rdy !== e_rdy) begin
                errors++; $display("FAIL rnd_in_rdy c=%0d got=%b want=%b", cyc, in_rdy, e_rdy);
            end
            if (al_vld !== m_pend) begin
                errors++; $display("FAIL rnd_al_vld c=%0d got=%b want=%b", cyc, al_vld, m_pend);
            end
            if (al_cmd_r !== m_alc) begin
                errors++; $display("FAIL rnd_al_cmd c=%0d got=%h want=%h", cyc, al_cmd_r, m_alc);
            end
            if (dl_vld !== e_dl) begin
                errors++; $display("FAIL rnd_dl c=%0d got=%b want=%b", cyc, dl_vld, e_dl);
            end
            if (out_vld !== m_ov) begin
                errors++; $display("FAIL rnd_out_vld c=%0d got=%b want=%b", cyc, out_vld, m_ov);
            end
            if (out_cmd !== m_oc) begin
                errors++; $display("FAIL rnd_out_cmd c=%0d got=%h want=%h", cyc, out_cmd, m_oc);
            end
            if (occ !== OW'($countones(ent_busy | m_pend))) begin
                errors++;
                $display("FAIL rnd_occ c=%0d got=%0d want=%0d", cyc, occ,
                         $countones(ent_busy | m_pend));
            end
            if (cancel_hit !== e_hit) begin
                errors++; $display("FAIL rnd_hit c=%0d got=%b want=%b", cyc, cancel_hit, e_hit);
            end
            // Advance the model by one clock.
            if (in_vld && e_rdy) begin
                m_pend = '0;
                for (int i = int'(N) - 1; i >= 0; i--) begin
                    if (fr[i]) begin
                        m_pend    = '0;
                        m_pend[i] = 1'b1;
                    end
                end
                m_alc = in_cmd;
            end else begin
                m_pend = '0;
            end
            if (g >= 0) begin
                m_ov  = 1'b1;
                m_oc  = ent_cmd[g];
                m_ptr = (g + 1) % int'(N);
            end else if (out_rdy || e_hit) begin
                m_ov = 1'b0;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_alloc_throughput();
        test_full_free();
        test_rr_drain();
        test_backpressure();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
